vm_multi_core: RTL and testbench

Parametrised successor of the single-product vending machine core. It serves `N_PROD` products, each with a run-time-loadable price and a stock counter. It accumulates coins of four denominations and issues change greedily, one coin per cycle. The block sits under `dut_top` in place of the fixed core and is driven by the existing VM in/out interfaces through a thin adapter.

---
 rtl/vm_pkg.sv | 38 +++
 rtl/vm_multi_core_if.sv | 40 ++++
 rtl/vm_change_gen.sv | 20 ++
 rtl/vm_multi_core.sv | 139 +++++++++++++
 tb/tb_vm_multi_core.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types, coin values and helpers for the multi-product vending core
package vm_pkg;

  localparam int V_5   = 5;
  localparam int V_10  = 10;
  localparam int V_25  = 25;
  localparam int V_100 = 100;

  typedef enum logic [1:0] {
    COIN_5   = 2'd0,
    COIN_10  = 2'd1,
    COIN_25  = 2'd2,
    COIN_100 = 2'd3
  } coin_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SOLD_OUT = 2'd1,
    ERR_CREDIT   = 2'd2,
    ERR_OVERFLOW = 2'd3
  } vm_err_t;

  typedef logic [1:0] vm_state_t;
  localparam vm_state_t ST_IDLE    = 2'd0;
  localparam vm_state_t ST_COLLECT = 2'd1;
  localparam vm_state_t ST_VEND    = 2'd2;
  localparam vm_state_t ST_CHANGE  = 2'd3;

  function automatic logic [6:0] coin_value(input coin_t c);
    case (c)
      COIN_5:   return 7'(V_5);
      COIN_10:  return 7'(V_10);
      COIN_25:  return 7'(V_25);
      default:  return 7'(V_100);
    endcase
  endfunction

endpackage

// File: rtl/vm_multi_core_if.sv
// rtl/vm_multi_core_if.sv - coin, selection, config and dispense signals of the vending core
interface vm_multi_core_if #(
  parameter int N_PROD   = 4,
  parameter int CREDIT_W = 10,
  parameter int STOCK_W  = 4
);
  localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                coin_ready;
  logic                sel_valid;
  logic [ID_W-1:0]     sel_id;
  logic                cancel;
  logic                cfg_we;
  logic [ID_W-1:0]     cfg_id;
  logic [CREDIT_W-1:0] cfg_price;
  logic [STOCK_W-1:0]  cfg_stock;
  logic                vend_valid;
  logic [ID_W-1:0]     vend_id;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic [CREDIT_W-1:0] credit;
  logic                err_valid;
  logic [1:0]          err_code;

  modport master (
    output coin_valid, coin_type, sel_valid, sel_id, cancel,
           cfg_we, cfg_id, cfg_price, cfg_stock,
    input  coin_ready, vend_valid, vend_id, change_valid, change_coin,
           credit, err_valid, err_code
  );

  modport slave (
    input  coin_valid, coin_type, sel_valid, sel_id, cancel,
           cfg_we, cfg_id, cfg_price, cfg_stock,
    output coin_ready, vend_valid, vend_id, change_valid, change_coin,
           credit, err_valid, err_code
  );
endinterface

// File: rtl/vm_change_gen.sv
// rtl/vm_change_gen.sv - greedy selector: largest coin not exceeding the given credit
module vm_change_gen
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 10
) (
  input  logic [CREDIT_W-1:0] credit,
  output coin_t               coin,
  output logic [CREDIT_W-1:0] value
);

  always_comb begin
    if (credit >= CREDIT_W'(V_100))     coin = COIN_100;
    else if (credit >= CREDIT_W'(V_25)) coin = COIN_25;
    else if (credit >= CREDIT_W'(V_10)) coin = COIN_10;
    else                                coin = COIN_5;
    value = CREDIT_W'(coin_value(coin));
  end

endmodule

// File: rtl/vm_multi_core.sv
// rtl/vm_multi_core.sv - multi-product vending core with per-product price/stock and greedy change
module vm_multi_core
  import vm_pkg::*;
#(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 10,
  parameter int MAX_CREDIT = 1000,
  parameter int STOCK_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  vm_multi_core_if.slave  bus
);
  localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  vm_state_t           state;
  logic [CREDIT_W-1:0] price [N_PROD];
  logic [STOCK_W-1:0]  stock [N_PROD];
  logic [ID_W-1:0]     vid;
  logic [CREDIT_W-1:0] credit_q;
  logic                vend_valid_q, change_valid_q, err_valid_q;
  logic [ID_W-1:0]     vend_id_q;
  logic [1:0]          change_coin_q, err_code_q;

  logic                coin_ready_c, coin_acc, sel_in_range;
  logic [CREDIT_W-1:0] coin_val, remaining, gen_in, gen_val, next_credit;
  logic [CREDIT_W:0]   sum;
  coin_t               gen_coin;

  assign coin_ready_c = (state == ST_IDLE || state == ST_COLLECT) && !bus.sel_valid && !bus.cancel;
  assign coin_acc     = bus.coin_valid && coin_ready_c;
  assign coin_val     = CREDIT_W'(coin_value(coin_t'(bus.coin_type)));
  assign sum          = {1'b0, credit_q} + {1'b0, coin_val};
  assign sel_in_range = 32'(bus.sel_id) < N_PROD;
  assign remaining    = credit_q - price[vid];

  // During VEND the first change coin is chosen from the post-purchase credit
  assign gen_in      = (state == ST_VEND) ? remaining : credit_q;
  assign next_credit = gen_in - gen_val;

  vm_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
    .credit (gen_in),
    .coin   (gen_coin),
    .value  (gen_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      credit_q       <= '0;
      vid            <= '0;
      vend_valid_q   <= 1'b0;
      vend_id_q      <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 2'd0;
      err_valid_q    <= 1'b0;
      err_code_q     <= ERR_NONE;
      for (int i = 0; i < N_PROD; i++) begin
        price[i] <= '0;
        stock[i] <= '0;
      end
    end else begin
      vend_valid_q   <= 1'b0;
      change_valid_q <= 1'b0;
      err_valid_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cfg_we) begin
            price[bus.cfg_id] <= bus.cfg_price;
            stock[bus.cfg_id] <= bus.cfg_stock;
          end
          if (coin_acc) begin
            credit_q <= coin_val;
            state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (bus.cancel) begin
            change_valid_q <= 1'b1;
            change_coin_q  <= gen_coin;
            credit_q       <= next_credit;
            state          <= (next_credit == '0) ? ST_IDLE : ST_CHANGE;
          end else if (bus.sel_valid) begin
            if (!sel_in_range || stock[bus.sel_id] == '0) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_SOLD_OUT;
            end else if (credit_q < price[bus.sel_id]) begin
              err_valid_q <= 1'b1;
              err_code_q  <= ERR_CREDIT;
            end else begin
              vid          <= bus.sel_id;
              vend_valid_q <= 1'b1;
              vend_id_q    <= bus.sel_id;
              state        <= ST_VEND;
            end
          end else if (coin_acc) begin
            if (sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
              credit_q <= sum[CREDIT_W-1:0];
            end else begin
              // Overflowing coin is bounced straight back as change
              err_valid_q    <= 1'b1;
              err_code_q     <= ERR_OVERFLOW;
              change_valid_q <= 1'b1;
              change_coin_q  <= bus.coin_type;
            end
          end
        end
        ST_VEND: begin
          stock[vid] <= stock[vid] - STOCK_W'(1);
          if (remaining == '0) begin
            credit_q <= '0;
            state    <= ST_IDLE;
          end else begin
            change_valid_q <= 1'b1;
            change_coin_q  <= gen_coin;
            credit_q       <= next_credit;
            state          <= (next_credit == '0) ? ST_IDLE : ST_CHANGE;
          end
        end
        default: begin
          change_valid_q <= 1'b1;
          change_coin_q  <= gen_coin;
          credit_q       <= next_credit;
          state          <= (next_credit == '0) ? ST_IDLE : ST_CHANGE;
        end
      endcase
    end
  end

  assign bus.coin_ready   = coin_ready_c;
  assign bus.credit       = credit_q;
  assign bus.vend_valid   = vend_valid_q;
  assign bus.vend_id      = vend_id_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.err_valid    = err_valid_q;
  assign bus.err_code     = err_code_q;

endmodule

// File: tb/tb_vm_multi_core.sv
// tb/tb_vm_multi_core.sv - scoreboard bench for the multi-product vending core
module tb_vm_multi_core;
  import vm_pkg::*;

  localparam logic [1:0] K_VEND = 2'd0;
  localparam logic [1:0] K_CHG  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] exp_q [$];

  vm_multi_core_if #(.N_PROD(4), .CREDIT_W(10), .STOCK_W(4)) bus ();

  vm_multi_core #(.N_PROD(4), .CREDIT_W(10), .MAX_CREDIT(1000), .STOCK_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [1:0] k, input logic [1:0] v);
    exp_q.push_back({k, v});
  endtask

  task automatic match_ev(input string tag, input logic [1:0] k, input logic [1:0] v);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_unexpected"}, 32'({k, v}), 32'hFFFF);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'({k, v}), 32'(e));
    end
  endtask

  // Output pulses are popped in err, change, vend order within a cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.err_valid)    match_ev("err", K_ERR, bus.err_code);
      if (bus.change_valid) match_ev("chg", K_CHG, bus.change_coin);
      if (bus.vend_valid)   match_ev("vend", K_VEND, bus.vend_id);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] t);
    bus.coin_valid = 1'b1;
    bus.coin_type  = t;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic select(input logic [1:0] id);
    bus.sel_valid = 1'b1;
    bus.sel_id    = id;
    tick();
    bus.sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] id, input logic [9:0] p, input logic [3:0] s);
    bus.cfg_we    = 1'b1;
    bus.cfg_id    = id;
    bus.cfg_price = p;
    bus.cfg_stock = s;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    bus.coin_valid = 1'b0; bus.coin_type = 2'd0; bus.sel_valid = 1'b0; bus.sel_id = '0;
    bus.cancel = 1'b0; bus.cfg_we = 1'b0; bus.cfg_id = '0; bus.cfg_price = '0; bus.cfg_stock = '0;
    repeat (2) tick();
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_coin_ready", 32'(bus.coin_ready), 1);
    chk("rst_pulses", 32'({bus.vend_valid, bus.change_valid, bus.err_valid}), 0);
    chk("rst_codes", 32'({bus.vend_id, bus.change_coin, bus.err_code}), 0);
    rst = 1'b0;
    tick();

    cfg(2'd2, 10'd65, 4'd1);
    cfg(2'd3, 10'd65, 4'd2);
    cfg(2'd1, 10'd0, 4'd3);

    // Buy product 2 with 100, change 25 + 10
    put_coin(COIN_100);
    chk("credit_100", 32'(bus.credit), 100);
    push_ev(K_VEND, 2'd2); push_ev(K_CHG, COIN_25); push_ev(K_CHG, COIN_10);
    select(2'd2);
    chk("vend_t1", 32'(bus.vend_valid), 1);
    tick();
    chk("chg_t2", 32'(bus.change_valid), 1);
    chk("credit_after_vend", 32'(bus.credit), 10);
    tick();
    chk("chg_t3", 32'(bus.change_valid), 1);
    tick();
    chk("buy_done_credit", 32'(bus.credit), 0);
    chk("buy_done_idle", 32'({bus.change_valid, bus.coin_ready}), 1);

    // Sold out, then cancel refund of 125
    put_coin(COIN_100); put_coin(COIN_25);
    push_ev(K_ERR, ERR_SOLD_OUT);
    select(2'd2);
    chk("soldout_err", 32'(bus.err_valid), 1);
    chk("soldout_credit", 32'(bus.credit), 125);
    push_ev(K_CHG, COIN_100); push_ev(K_CHG, COIN_25);
    do_cancel();
    chk("cancel_t1", 32'(bus.change_valid), 1);
    repeat (2) tick();
    chk("cancel_done", 32'(bus.credit), 0);

    // Insufficient credit keeps COLLECT: a further coin adds rather than restarts
    put_coin(COIN_25); put_coin(COIN_25);
    push_ev(K_ERR, ERR_CREDIT);
    select(2'd3);
    chk("insuff_credit", 32'(bus.credit), 50);
    put_coin(COIN_10);
    chk("insuff_collect", 32'(bus.credit), 60);
    push_ev(K_CHG, COIN_25); push_ev(K_CHG, COIN_25); push_ev(K_CHG, COIN_10);
    do_cancel();
    repeat (3) tick();
    chk("insuff_refund", 32'(bus.credit), 0);

    // Overflow at 950 bounces the 100, then 25 is accepted
    repeat (9) put_coin(COIN_100);
    put_coin(COIN_25); put_coin(COIN_25);
    chk("credit_950", 32'(bus.credit), 950);
    push_ev(K_ERR, ERR_OVERFLOW); push_ev(K_CHG, COIN_100);
    put_coin(COIN_100);
    chk("ovf_pulses", 32'({bus.err_valid, bus.change_valid}), 3);
    chk("ovf_credit", 32'(bus.credit), 950);
    put_coin(COIN_25);
    chk("credit_975", 32'(bus.credit), 975);
    for (int i = 0; i < 9; i++) push_ev(K_CHG, COIN_100);
    for (int i = 0; i < 3; i++) push_ev(K_CHG, COIN_25);
    do_cancel();
    repeat (12) tick();
    chk("ovf_refund", 32'(bus.credit), 0);

    // Coin offered with cancel is refused; refund is prior credit only
    put_coin(COIN_25); put_coin(COIN_10);
    bus.coin_valid = 1'b1; bus.coin_type = COIN_100; bus.cancel = 1'b1;
    #1;
    chk("coin_cancel_ready", 32'(bus.coin_ready), 0);
    push_ev(K_CHG, COIN_25); push_ev(K_CHG, COIN_10);
    tick();
    bus.coin_valid = 1'b0; bus.cancel = 1'b0;
    repeat (2) tick();
    chk("coin_cancel_done", 32'(bus.credit), 0);

    // Zero price vends and refunds everything
    put_coin(COIN_10);
    push_ev(K_VEND, 2'd1); push_ev(K_CHG, COIN_10);
    select(2'd1);
    repeat (3) tick();
    chk("price0_credit", 32'(bus.credit), 0);

    // Reset during CHANGE with credit 35
    put_coin(COIN_100); put_coin(COIN_25); put_coin(COIN_10);
    push_ev(K_CHG, COIN_100);
    do_cancel();
    chk("change_35", 32'(bus.credit), 35);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_credit", 32'(bus.credit), 0);
    chk("midrst_pulses", 32'({bus.vend_valid, bus.change_valid, bus.err_valid}), 0);
    chk("midrst_ready", 32'(bus.coin_ready), 1);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("postrst_quiet", 32'({bus.change_valid, bus.credit}), 0);
    put_coin(COIN_5);
    push_ev(K_ERR, ERR_SOLD_OUT);
    select(2'd3);
    chk("postrst_soldout", 32'(bus.err_valid), 1);
    push_ev(K_CHG, COIN_5);
    do_cancel();
    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
